// File: rtl/intr_ctrl_n_pkg.sv
// Shared constants and types for the N-source interrupt controller.
package intr_pkg;

  localparam int unsigned CODE_NONE = 0;

  localparam logic [1:0] CFG_ENABLE  = 2'd0;
  localparam logic [1:0] CFG_BASE    = 2'd1;
  localparam logic [1:0] CFG_PENDING = 2'd2;
  localparam logic [1:0] CFG_STATUS  = 2'd3;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_BUSY = 1'b1
  } state_t;

  localparam logic [31:0] VEC_NONE = 32'hFFFF_FFFF;

  // Vector = base page in the upper half, code scaled by 16 in the lower half.
  function automatic logic [31:0] vec_addr(input logic [15:0] base_hi, input logic [15:0] code16);
    logic [15:0] lo;
    lo = code16 << 4;
    return {base_hi, lo};
  endfunction

endpackage

// File: rtl/intr_ctrl_n_if.sv
// Request, core handshake and config bus of the interrupt controller.
interface intr_ctrl_n_if #(
  parameter int unsigned N_SRC  = 8,
  parameter int unsigned CODE_W = 5
);
  logic [N_SRC-1:0]  req;
  logic              gie;
  logic              ack;
  logic [N_SRC-1:0]  src_ack;
  logic              irq_valid;
  logic [CODE_W-1:0] code;
  logic [31:0]       entry_addr;
  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic [31:0]       cfg_wd;
  logic [31:0]       cfg_rd;

  // Devices / core side.
  modport master (
    output req, gie, ack, cfg_we, cfg_addr, cfg_wd,
    input  src_ack, irq_valid, code, entry_addr, cfg_rd
  );

  // Controller side.
  modport slave (
    input  req, gie, ack, cfg_we, cfg_addr, cfg_wd,
    output src_ack, irq_valid, code, entry_addr, cfg_rd
  );
endinterface

// File: rtl/intr_ctrl_n_prio_enc.sv
// Lowest-index-wins priority encoder: returns index+1, or 0 when nothing is set.
module prio_enc_n #(
  parameter int unsigned N      = 8,
  parameter int unsigned CODE_W = 5
) (
  input  logic [N-1:0]      vec,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  // Scan from the top down so the lowest set index is the last to assign.
  always_comb begin
    code = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec[i]) code = CODE_W'(i + 1);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/intr_ctrl_n.sv
// Fixed-priority interrupt controller with per-source edge/level mode, enable mask,
// gie gating of asynchronous sources and a latched code/vector handshake.
module intr_ctrl_n #(
  parameter int unsigned      N_SRC      = 8,
  parameter int unsigned      CODE_W     = 5,
  parameter logic [N_SRC-1:0] EDGE_MASK  = '0,
  parameter logic [N_SRC-1:0] ASYNC_MASK = N_SRC'(32'hC0)
) (
  input logic          clk,
  input logic          rst,
  intr_ctrl_n_if.slave bus
);
  import intr_pkg::*;

  state_t            state_q;
  logic [CODE_W-1:0] code_q;
  logic              irq_valid_q;
  logic [N_SRC-1:0]  enable_q;
  logic [N_SRC-1:0]  pend_q;  // only edge-mode bits are ever set
  logic [N_SRC-1:0]  req_q;
  logic [31:0]       base_q;

  logic [N_SRC-1:0]  pend;
  logic [N_SRC-1:0]  elig;
  logic [N_SRC-1:0]  src_ack;
  logic [N_SRC-1:0]  pend_set;
  logic [N_SRC-1:0]  pend_clr;
  logic [N_SRC-1:0]  pend_d;
  logic [CODE_W-1:0] enc_code;
  logic              enc_any;
  logic              w1c;
  logic [31:0]       cfg_rd;
  logic              unused_wd;

  assign unused_wd = ^bus.cfg_wd;

  // Level sources are transparent; edge sources come from the latch.
  assign pend = (pend_q & EDGE_MASK) | (bus.req & ~EDGE_MASK);
  assign elig = pend & enable_q & (~ASYNC_MASK | {N_SRC{bus.gie}});

  prio_enc_n #(
    .N      (N_SRC),
    .CODE_W (CODE_W)
  ) u_prio_enc (
    .vec  (elig),
    .code (enc_code),
    .any  (enc_any)
  );

  // One-hot acknowledge to the serviced source while the core accepts it.
  always_comb begin
    src_ack = '0;
    if (state_q == STATE_BUSY && bus.ack && !rst) begin
      for (int i = 0; i < int'(N_SRC); i++) begin
        src_ack[i] = (code_q == CODE_W'(i + 1));
      end
    end
  end

  // Edge latch: a new rising edge beats any clear arriving in the same cycle.
  assign w1c      = bus.cfg_we && (bus.cfg_addr == CFG_PENDING);
  assign pend_set = bus.req & ~req_q;
  assign pend_clr = src_ack | (w1c ? bus.cfg_wd[N_SRC-1:0] : '0);
  assign pend_d   = ((pend_q & ~pend_clr) | pend_set) & EDGE_MASK;

  // Config registers, edge latches and request history.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= '0;
      base_q   <= '0;
      pend_q   <= '0;
      req_q    <= '0;
    end else begin
      pend_q <= pend_d;
      req_q  <= bus.req;
      if (bus.cfg_we && bus.cfg_addr == CFG_ENABLE) enable_q <= bus.cfg_wd[N_SRC-1:0];
      if (bus.cfg_we && bus.cfg_addr == CFG_BASE)   base_q   <= {bus.cfg_wd[31:16], 16'h0};
    end
  end

  // Presentation FSM: latch the winner, hold it until ack, then force one idle cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= STATE_IDLE;
      code_q      <= CODE_W'(CODE_NONE);
      irq_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        STATE_IDLE: begin
          if (enc_any) begin
            state_q     <= STATE_BUSY;
            code_q      <= enc_code;
            irq_valid_q <= 1'b1;
          end
        end
        STATE_BUSY: begin
          if (bus.ack) begin
            state_q     <= STATE_IDLE;
            code_q      <= CODE_W'(CODE_NONE);
            irq_valid_q <= 1'b0;
          end
        end
        default: state_q <= STATE_IDLE;
      endcase
    end
  end

  // Combinational config read mux.
  always_comb begin
    cfg_rd = '0;
    unique case (bus.cfg_addr)
      CFG_ENABLE:  cfg_rd = 32'(enable_q);
      CFG_BASE:    cfg_rd = base_q;
      CFG_PENDING: cfg_rd = 32'(pend);
      CFG_STATUS: begin
        cfg_rd     = 32'(code_q);
        cfg_rd[31] = irq_valid_q;
      end
      default:     cfg_rd = '0;
    endcase
  end

  assign bus.cfg_rd     = cfg_rd;
  assign bus.src_ack    = src_ack;
  assign bus.irq_valid  = irq_valid_q;
  assign bus.code       = code_q;
  assign bus.entry_addr = (code_q == CODE_W'(CODE_NONE)) ? VEC_NONE :
                          vec_addr(base_q[31:16], 16'(code_q));

endmodule

// File: tb/tb_intr_ctrl_n.sv
// Scoreboard bench for intr_ctrl_n: a behavioural model predicts every cycle's outputs,
// a separate monitor pops and compares them mid-cycle.
module tb_intr_ctrl_n;
  localparam int unsigned N  = 8;
  localparam int unsigned CW = 5;
  localparam logic [N-1:0] EDGE  = 8'h0A;  // sources 1 and 3 are edge latched
  localparam logic [N-1:0] ASYNC = 8'hC0;

  typedef struct {
    logic          v;
    logic [CW-1:0] code;
    logic [31:0]   entry;
    logic [N-1:0]  sack;
    logic [31:0]   rd;
  } exp_t;

  logic clk;
  logic rst;
  intr_ctrl_n_if #(.N_SRC(N), .CODE_W(CW)) bus ();

  intr_ctrl_n #(
    .N_SRC      (N),
    .CODE_W     (CW),
    .EDGE_MASK  (EDGE),
    .ASYNC_MASK (ASYNC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  // Reference model state.
  bit [N-1:0] m_pend;
  bit [N-1:0] m_en;
  bit [N-1:0] m_prev;
  bit [31:0]  m_base;
  bit         m_busy;
  int         m_code;

  function automatic bit [N-1:0] m_view();
    bit [N-1:0] v;
    for (int i = 0; i < int'(N); i++) v[i] = EDGE[i] ? m_pend[i] : bus.req[i];
    return v;
  endfunction

  function automatic int m_pick();
    bit [N-1:0] v;
    v = m_view();
    for (int i = 0; i < int'(N); i++) begin
      if (v[i] && m_en[i] && (bus.gie || !ASYNC[i])) return i;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int pick;
    int served;
    if (rst) begin
      m_pend = '0; m_en = '0; m_prev = '0; m_base = '0; m_busy = 1'b0; m_code = 0;
    end else begin
      pick   = m_pick();
      served = (m_busy && bus.ack) ? m_code - 1 : -1;
      for (int i = 0; i < int'(N); i++) begin
        if (EDGE[i]) begin
          if (bus.req[i] && !m_prev[i]) m_pend[i] = 1'b1;
          else if (i == served || (bus.cfg_we && bus.cfg_addr == 2'd2 && bus.cfg_wd[i]))
            m_pend[i] = 1'b0;
        end
      end
      if (bus.cfg_we && bus.cfg_addr == 2'd0) m_en = bus.cfg_wd[N-1:0];
      if (bus.cfg_we && bus.cfg_addr == 2'd1) m_base = bus.cfg_wd & 32'hFFFF_0000;
      if (m_busy) begin
        if (bus.ack) begin m_busy = 1'b0; m_code = 0; end
      end else if (pick >= 0) begin
        m_busy = 1'b1;
        m_code = pick + 1;
      end
      m_prev = bus.req;
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.v     = m_busy;
    e.code  = m_code[CW-1:0];
    e.entry = (m_code == 0) ? 32'hFFFF_FFFF : {m_base[31:16], 16'(m_code * 16)};
    e.sack  = (m_busy && bus.ack && !rst) ? N'(1) << (m_code - 1) : '0;
    case (bus.cfg_addr)
      2'd0:    e.rd = 32'(m_en);
      2'd1:    e.rd = m_base;
      2'd2:    e.rd = 32'(m_view());
      default: e.rd = {m_busy, 26'b0, m_code[CW-1:0]};
    endcase
    return e;
  endfunction

  // Push this cycle's expectation, then advance the model across the edge.
  task automatic step();
    chk_en = 1'b1;
    q.push_back(predict());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wd = d;
    step();
    bus.cfg_we = 1'b0; bus.cfg_wd = '0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: every mid-cycle sample is matched against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (q.size() == 0) begin
        check("scoreboard_underrun", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("irq_valid",  32'(bus.irq_valid), 32'(e.v));
        check("code",       32'(bus.code),      32'(e.code));
        check("entry_addr", bus.entry_addr,     e.entry);
        check("src_ack",    32'(bus.src_ack),   32'(e.sack));
        check("cfg_rd",     bus.cfg_rd,         e.rd);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.req = '0; bus.gie = 1'b0; bus.ack = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_wd = '0;
    @(posedge clk);
    model_edge();
    #1;
    step();
    bus.cfg_addr = 2'd3;
    step();
    rst = 1'b0;

    // Two level sources: code 3 first, then code 6 after the idle gap.
    cfg_write(2'd0, 32'hFF);
    bus.req = 8'h24;
    step(); step();
    bus.ack = 1'b1; bus.req = 8'h20;
    step();
    bus.ack = 1'b0;
    step(); step();

    // No pre-emption by a higher-priority arrival.
    bus.req = 8'h21;
    step(); step(); step();
    bus.ack = 1'b1; bus.req = 8'h01;
    step();
    bus.ack = 1'b0;
    step(); step();
    bus.ack = 1'b1; bus.req = 8'h00;
    step();
    bus.ack = 1'b0;
    step();

    // Async source held off by gie, then vectored through BASE.
    cfg_write(2'd1, 32'h1234_5678);
    bus.req = 8'h80;
    repeat (10) step();
    bus.gie = 1'b1;
    step(); step();
    bus.ack = 1'b1; bus.req = 8'h00;
    step();
    bus.ack = 1'b0;
    step();

    // Edge source 1 pulses while busy on edge source 3.
    bus.req = 8'h08; step(); bus.req = 8'h00; step();
    bus.req = 8'h02; step(); bus.req = 8'h00;
    bus.cfg_addr = 2'd2;
    step(); step();
    bus.ack = 1'b1; step(); bus.ack = 1'b0;
    step(); step();
    bus.ack = 1'b1; step(); bus.ack = 1'b0;
    step(); step();

    // Rising edge and W1C in the same cycle: the set must win.
    cfg_write(2'd0, 32'hFD);
    bus.req = 8'h02;
    cfg_write(2'd2, 32'h2);
    bus.req = 8'h00;
    step();
    cfg_write(2'd2, 32'h2);
    step();
    cfg_write(2'd0, 32'hFF);

    // ack while idle, then reset in the middle of BUSY.
    bus.ack = 1'b1; step(); bus.ack = 1'b0; step();
    bus.req = 8'h10; step(); step();
    rst = 1'b1; bus.cfg_addr = 2'd3; step();
    rst = 1'b0; bus.req = 8'h00; step();
    cfg_write(2'd0, 32'hFF);

    // Randomised traffic.
    for (int c = 0; c < 2000; c++) begin
      bus.req  = bus.req ^ N'($urandom & $urandom & $urandom);
      bus.ack  = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 9) == 0) bus.gie = ~bus.gie;
      bus.cfg_addr = 2'($urandom);
      bus.cfg_we   = ($urandom_range(0, 15) == 0);
      bus.cfg_wd   = $urandom;
      if (bus.cfg_we && bus.cfg_addr == 2'd0) bus.cfg_wd = bus.cfg_wd | 32'h3C;
      rst = ($urandom_range(0, 299) == 0);
      step();
      if (rst) begin
        rst = 1'b0; bus.cfg_we = 1'b0;
        cfg_write(2'd0, 32'hFF);
      end
    end
    rst = 1'b0; bus.cfg_we = 1'b0; bus.ack = 1'b0;

    chk_en = 1'b0;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intr_ctrl_n.md
Name: intr_ctrl_n

Overview:
- Parametrised interrupt controller: N_SRC request lines, fixed priority (source 0 highest).
- Per-source edge/level mode, per-source enable mask, global-enable gating for asynchronous sources.
- Latched code/vector handshake with the core's exception unit.
- Sits between the pipeline/device request lines and the core's exception sequencer. Generalises the fixed 8-source encoder to N sources, adds edge latching, a masking register file and correct ack-clear behaviour.

Parameters:
- N_SRC, 8, number of request sources (1..30).
- CODE_W, 5, code width; must satisfy 2^CODE_W > N_SRC.
- EDGE_MASK, 0, bit i=1: source i is rising-edge latched; bit i=0: level.
- ASYNC_MASK, 8'hC0, bit i=1: source i is additionally gated by gie.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  N_SRC  raw request lines, bit i = source i
- gie  in  1  global interrupt enable (MSR[EE])
- ack  in  1  core accepted the presented interrupt
- src_ack  out  N_SRC  one-hot acknowledge to the serviced source
- irq_valid  out  1  interrupt code/vector being presented
- code  out  CODE_W  0 = NONE; source i = i+1
- entry_addr  out  32  vector address
- cfg_we  in  1  config write strobe
- cfg_addr  in  2  0=ENABLE, 1=BASE, 2=PENDING (W1C), 3=STATUS (read-only)
- cfg_wd  in  32  config write data
- cfg_rd  out  32  config read data, combinational

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-high.
- Reset values: state IDLE, code=0, irq_valid=0, src_ack=0, enable=0, base=0, pend=0, req_d=0. entry_addr=32'hFFFF_FFFF while code=0.
- Pending, edge source: pend[i] set when req[i]&~req_d[i].
  - Cleared by a src_ack[i] cycle, or by a PENDING write with cfg_wd[i]=1.
  - If a set and a clear land in the same cycle, set wins.
- Pending, level source: pend[i] = req[i], combinational; W1C has no effect.
- Eligibility: elig = pend & enable & (~ASYNC_MASK | {N_SRC{gie}}).
- FSM IDLE: if elig≠0, register code = (lowest set index)+1 and go BUSY. irq_valid rises the cycle after elig becomes nonzero (1-cycle latency).
- FSM BUSY:
  - irq_valid=1; code is frozen. There is no pre-emption: higher-priority arrivals, mask writes and gie changes do not alter the code.
  - On ack: src_ack[code-1]=1 in the same cycle (combinational on ack&BUSY). Next cycle: code=0, irq_valid=0, state IDLE.
  - Minimum one idle cycle between successive interrupts.
- ack while IDLE: ignored, src_ack=0.
- entry_addr = {base[31:16], 7'b0, code, 4'b0}, zero-extended to fill the 16 LSBs; all-ones when code=0.
- Config writes:
  - ENABLE: enable <= cfg_wd[N_SRC-1:0].
  - BASE: base <= cfg_wd with [15:0] forced 0.
  - A STATUS write is ignored.
- Config reads: ENABLE → enable; BASE → base; PENDING → pend; STATUS → {irq_valid, 26'b0 padding, code} (code in LSBs). Unused upper bits read 0.
- rst mid-BUSY: returns to IDLE next edge with no src_ack pulse; latched edge pendings are lost.

Decomposition:
- Shared package intr_pkg: CODE_NONE=0, CFG_ENABLE/BASE/PENDING/STATUS addresses, STATE_IDLE/STATE_BUSY encodings, VEC_NONE=32'hFFFF_FFFF.
- One sub-module: prio_enc_n (N-bit one-hot-free lowest-index priority encoder → index+1, 0 when empty, plus any flag). It is purely combinational and instantiated once.

Test Plan:
- Reset, then ENABLE=0xFF, req=0x24 (src2,5 level) → one cycle later code=3, irq_valid=1; ack → src_ack=0x04; next cycle code=0; following cycle code=6.
- BUSY on code=6, raise req[0] → code stays 6 until ack; after the gap cycle code=1.
- gie=0, req[7] (async) only → irq_valid stays 0 for 10 cycles; gie=1 → code=8 next cycle, entry_addr={base[31:16],16'h0080} with BASE=0x1234_0000 → 0x1234_0080.
- EDGE_MASK bit1: 1-cycle pulse on req[1] while BUSY on another source → PENDING reads 0x2; serviced after; src_ack[1] clears it; PENDING reads 0.
- Rising edge on req[1] in the same cycle as W1C 0x2 → pend[1] remains 1.
- ack while IDLE → src_ack=0, state unchanged. rst during BUSY → irq_valid=0, code=0, no src_ack pulse.
